// File: rtl/cn_serial.sv
// Time-multiplexed offset-min-sum check node: accumulates min1/min2/argmin/parity
// over up to DEG serial V2C messages, then streams one C2V message per edge.
module cn_serial #(
  parameter int INT    = 8,
  parameter int FRAC   = 8,
  parameter int DEG    = 10,
  parameter int OFFSET = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INT+FRAC-1:0]   in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INT+FRAC-1:0]   out_data,
  output logic                  out_last,
  output logic                  deg_err
);

  localparam int W  = INT + FRAC;
  localparam int CW = $clog2(DEG + 1);
  localparam logic [W-2:0] MAXMAG   = '1;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-2:0] OFF      = (W-1)'(OFFSET);

  typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [W-2:0]    min1, min2;
  logic [CW-1:0]   idx, cnt, ecnt;
  logic            parity;
  logic [DEG-1:0]  sgn;

  logic            acc, at_cap, fin, emit_hs;
  logic [W-2:0]    in_mag, mag_e, mag_o;
  logic [W-1:0]    mag_w;
  logic            sgn_sel, sign_o;

  assign acc     = in_valid && (state == ACCUM);
  assign at_cap  = (cnt == CW'(DEG - 1));
  assign fin     = (ecnt == cnt - CW'(1));
  assign emit_hs = (state == EMIT) && out_ready;

  // Most-negative input has no positive twin; it saturates to MAXMAG.
  always_comb begin
    if (in_data == MOST_NEG)
      in_mag = MAXMAG;
    else if (in_data[W-1])
      in_mag = ~in_data[W-2:0] + (W-1)'(1);
    else
      in_mag = in_data[W-2:0];
  end

  // FSM next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    deg_err   = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (acc) begin
          if (in_last || at_cap) state_nxt = EMIT;
          deg_err = !in_last && at_cap;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && fin) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Accumulator and emit counter; re-armed on reset or on the final output handshake.
  always_ff @(posedge clk) begin
    if (rst || (emit_hs && fin)) begin
      min1   <= MAXMAG;
      min2   <= MAXMAG;
      idx    <= '0;
      cnt    <= '0;
      ecnt   <= '0;
      parity <= 1'b0;
      sgn    <= '0;
    end else if (acc) begin
      // Strict compare keeps the earlier index on ties.
      if (in_mag < min1) begin
        min2 <= min1;
        min1 <= in_mag;
        idx  <= cnt;
      end else if (in_mag < min2) begin
        min2 <= in_mag;
      end
      for (int i = 0; i < DEG; i++)
        if (cnt == CW'(i)) sgn[i] <= in_data[W-1];
      parity <= parity ^ in_data[W-1];
      cnt    <= cnt + CW'(1);
    end else if (emit_hs) begin
      ecnt <= ecnt + CW'(1);
    end
  end

  // Output message for edge ecnt; purely a function of held state, so it is
  // naturally stable while out_ready is low.
  always_comb begin
    sgn_sel = 1'b0;
    for (int i = 0; i < DEG; i++)
      if (ecnt == CW'(i)) sgn_sel = sgn[i];
    mag_e  = (ecnt == idx) ? min2 : min1;
    mag_o  = (mag_e > OFF) ? (mag_e - OFF) : '0;
    mag_w  = {1'b0, mag_o};
    sign_o = parity ^ sgn_sel;
    if (state == EMIT) begin
      out_data = sign_o ? -mag_w : mag_w;
      out_last = fin;
    end else begin
      out_data = '0;
      out_last = 1'b0;
    end
  end

endmodule

// File: tb/tb_cn_serial.sv
// Bench for cn_serial: fixed vector table, directed corner sequences and random
// frames checked against an edge-exclusive min/parity reference model.
module tb_cn_serial;
  localparam int W = 16, DEG = 10, OFFSET = 16;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last, deg_err;
  logic [W-1:0]  in_data, out_data;

  cn_serial #(.INT(8), .FRAC(8), .DEG(DEG), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .deg_err(deg_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [W-1:0] fr [DEG];
  logic [W-1:0] ex [DEG];

  typedef struct packed {
    logic [3:0]        n;
    logic [1:0]        mode;
    logic [9:0][15:0]  d;
    logic [9:0][15:0]  e;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int smag(input logic [W-1:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  // Each edge sees the min magnitude and sign parity of all the *other* edges.
  function automatic void model(input int n);
    for (int e = 0; e < n; e++) begin
      int m = 32767;
      bit s = 0;
      for (int j = 0; j < n; j++)
        if (j != e) begin
          if (smag(fr[j]) < m) m = smag(fr[j]);
          s ^= fr[j][W-1];
        end
      m = (m > OFFSET) ? m - OFFSET : 0;
      ex[e] = s ? W'(-m) : W'(m);
    end
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h0000;
      2: return W'($urandom_range(0, 40) - 20);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic send(input int n, input bit use_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'($urandom);
        #1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
      end
      @(negedge clk);
      in_valid = 1'b1; in_data = fr[i]; in_last = use_last && (i == n - 1);
      #1;
      chk("acc_in_ready", in_ready, 1);
      chk("acc_out_valid", out_valid, 0);
      chk("deg_err", deg_err, (!use_last && i == DEG - 1));
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1
  task automatic recv(input int n, input int mode, input bit keep, input logic [W-1:0] nxt);
    int k = 0, cyc = 0;
    bit first = 1;
    while (k < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (first) begin
        if (keep) begin in_valid = 1'b1; in_data = nxt; in_last = 1'b0; end
        else in_valid = 1'b0;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom);
        default: out_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
      endcase
      #1;
      if (first) chk("first_out_latency", out_valid, 1);
      first = 0;
      if (out_valid) begin
        chk($sformatf("out_data[%0d]", k), out_data, ex[k]);
        chk($sformatf("out_last[%0d]", k), out_last, (k == n - 1));
        chk("emit_in_ready", in_ready, 0);
        chk("emit_deg_err", deg_err, 0);
        if (out_ready) k++;
      end
    end
    if (k < n) chk("recv_timeout", k, n);
    if (!keep) begin
      @(negedge clk);
      out_ready = 1'($urandom);
      #1;
      chk("post_in_ready", in_ready, 1);
      chk("post_out_valid", out_valid, 0);
      chk("post_out_data", out_data, 0);
    end
  endtask

  initial begin
    tbl[0].n = 10; tbl[0].mode = 2;
    tbl[0].d = {16'h0A00, 16'h0900, 16'h0800, 16'h0700, 16'h0600,
                16'h0400, 16'h0500, 16'h0100, 16'hFE00, 16'h0300};
    tbl[0].e = {16'hFF10, 16'hFF10, 16'hFF10, 16'hFF10, 16'hFF10,
                16'hFF10, 16'hFF10, 16'hFE10, 16'h00F0, 16'hFF10};
    tbl[1].n = 3; tbl[1].mode = 1;
    tbl[1].d = {112'h0, 16'h0090, 16'h0050, 16'h0050};
    tbl[1].e = {112'h0, 16'h0040, 16'h0040, 16'h0040};
    tbl[2].n = 2; tbl[2].mode = 0;
    tbl[2].d = {128'h0, 16'h0001, 16'h8000};
    tbl[2].e = {128'h0, 16'h8011, 16'h0000};
    tbl[3].n = 1; tbl[3].mode = 0;
    tbl[3].d = {144'h0, 16'h0123};
    tbl[3].e = {144'h0, 16'h7FEF};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_deg_err", deg_err, 0);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < int'(tbl[t].n); i++) begin
        fr[i] = tbl[t].d[i];
        ex[i] = tbl[t].e[i];
      end
      send(int'(tbl[t].n), 1, 0);
      recv(int'(tbl[t].n), int'(tbl[t].mode), 0, '0);
    end

    // DEG beats without in_last, with an 11th beat waiting during EMIT
    begin
      logic [W-1:0] nxt;
      for (int i = 0; i < DEG; i++) fr[i] = rnd_val();
      model(DEG);
      send(DEG, 0, 0);
      nxt = rnd_val();
      recv(DEG, 0, 1, nxt);
      fr[0] = nxt; fr[1] = rnd_val();
      model(2);
      send(2, 1, 0);
      recv(2, 1, 0, '0);
    end

    // Reset after 4 beats of a degree-6 check, then a clean degree-2 check
    for (int i = 0; i < 4; i++) fr[i] = rnd_val();
    send(4, 0, 0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    fr[0] = 16'h0010; fr[1] = 16'hFFE0;
    ex[0] = 16'hFFF0; ex[1] = 16'h0000;
    send(2, 1, 0);
    recv(2, 0, 0, '0);

    // Reset in the middle of EMIT
    for (int i = 0; i < 5; i++) fr[i] = rnd_val();
    send(5, 1, 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    #1;
    chk("emitrst_in_ready", in_ready, 1);
    chk("emitrst_out_valid", out_valid, 0);
    chk("emitrst_out_last", out_last, 0);

    for (int r = 0; r < 40; r++) begin
      int n;
      n = $urandom_range(1, DEG);
      for (int i = 0; i < n; i++) fr[i] = rnd_val();
      model(n);
      send(n, 1, 1);
      recv(n, 1, 0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
